// File: rtl/exe_stage_mc.sv
// Execute stage: single-cycle ALU ops plus a 32-iteration shift-add multiplier.
// Latency: 1 cycle for ALU ops, 33 cycles from presentation for MUL.
// Backpressure: stall holds the upstream ID/EXE slot while a MUL is in flight.
module exe_stage_mc (
    input  logic        clk,
    input  logic        rst,
    input  logic        validIn,
    input  logic        flush,
    input  logic [3:0]  EXE_CMD_IN,
    input  logic [31:0] val1In,
    input  logic [31:0] val2In,
    input  logic [31:0] ST_valueIn,
    input  logic [4:0]  destIn,
    input  logic        MEM_R_EN_IN,
    input  logic        MEM_W_EN_IN,
    input  logic        WB_EN_IN,
    output logic [31:0] ALU_result,
    output logic [31:0] ST_value,
    output logic [4:0]  dest,
    output logic        MEM_R_EN,
    output logic        MEM_W_EN,
    output logic        WB_EN,
    output logic        valid,
    output logic        stall
);

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SLL = 4'b1000;
    localparam logic [3:0] CMD_SRL = 4'b1001;
    localparam logic [3:0] CMD_SRA = 4'b1010;
    localparam logic [3:0] CMD_MUL = 4'b1100;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] st_cap_q, st_cap_d;
    logic [4:0]  dest_cap_q, dest_cap_d;
    logic        mr_cap_q, mr_cap_d;
    logic        mw_cap_q, mw_cap_d;
    logic        wb_cap_q, wb_cap_d;

    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] st_value_q, st_value_d;
    logic [4:0]  dest_q, dest_d;
    logic        mem_r_en_q, mem_r_en_d;
    logic        mem_w_en_q, mem_w_en_d;
    logic        wb_en_q, wb_en_d;
    logic        valid_q, valid_d;

    logic [31:0] alu_res;
    logic [31:0] acc_sum;
    logic        stall_c;

    // Single-cycle ALU; MUL and undefined codes yield 0 here.
    always_comb begin
        alu_res = 32'd0;
        case (EXE_CMD_IN)
            CMD_ADD: alu_res = val1In + val2In;
            CMD_SUB: alu_res = val1In - val2In;
            CMD_AND: alu_res = val1In & val2In;
            CMD_OR:  alu_res = val1In | val2In;
            CMD_NOR: alu_res = ~(val1In | val2In);
            CMD_XOR: alu_res = val1In ^ val2In;
            CMD_SLL: alu_res = val1In << val2In[4:0];
            CMD_SRL: alu_res = val1In >> val2In[4:0];
            CMD_SRA: alu_res = $unsigned($signed(val1In) >>> val2In[4:0]);
            default: alu_res = 32'd0;
        endcase
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    end

    // Next-state, datapath and stall; outputs default to a bubble with data held.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        st_cap_d     = st_cap_q;
        dest_cap_d   = dest_cap_q;
        mr_cap_d     = mr_cap_q;
        mw_cap_d     = mw_cap_q;
        wb_cap_d     = wb_cap_q;
        alu_result_d = alu_result_q;
        st_value_d   = st_value_q;
        dest_d       = dest_q;
        mem_r_en_d   = 1'b0;
        mem_w_en_d   = 1'b0;
        wb_en_d      = 1'b0;
        valid_d      = 1'b0;
        stall_c      = 1'b0;

        if (flush) begin
            // Kill wins over everything, including a completing multiply.
            state_d = IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (validIn) begin
                        if (EXE_CMD_IN == CMD_MUL) begin
                            stall_c    = 1'b1;
                            mcand_d    = val1In;
                            mplier_d   = val2In;
                            acc_d      = 32'd0;
                            st_cap_d   = ST_valueIn;
                            dest_cap_d = destIn;
                            mr_cap_d   = MEM_R_EN_IN;
                            mw_cap_d   = MEM_W_EN_IN;
                            wb_cap_d   = WB_EN_IN;
                            cnt_d      = 5'd0;
                            state_d    = BUSY;
                        end else begin
                            alu_result_d = alu_res;
                            st_value_d   = ST_valueIn;
                            dest_d       = destIn;
                            mem_r_en_d   = MEM_R_EN_IN;
                            mem_w_en_d   = MEM_W_EN_IN;
                            wb_en_d      = WB_EN_IN;
                            valid_d      = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == 5'd31) begin
                        // Last iteration folds straight into the output register;
                        // stall drops so upstream advances on this same edge.
                        alu_result_d = acc_sum;
                        st_value_d   = st_cap_q;
                        dest_d       = dest_cap_q;
                        mem_r_en_d   = mr_cap_q;
                        mem_w_en_d   = mw_cap_q;
                        wb_en_d      = wb_cap_q;
                        valid_d      = 1'b1;
                        cnt_d        = 5'd0;
                        state_d      = IDLE;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end
            endcase
        end
    end

    // Reset must drop stall immediately, even before the state register settles.
    assign stall = stall_c & ~rst;

    // State, operand and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 5'd0;
            mcand_q      <= 32'd0;
            mplier_q     <= 32'd0;
            acc_q        <= 32'd0;
            st_cap_q     <= 32'd0;
            dest_cap_q   <= 5'd0;
            mr_cap_q     <= 1'b0;
            mw_cap_q     <= 1'b0;
            wb_cap_q     <= 1'b0;
            alu_result_q <= 32'd0;
            st_value_q   <= 32'd0;
            dest_q       <= 5'd0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            wb_en_q      <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            st_cap_q     <= st_cap_d;
            dest_cap_q   <= dest_cap_d;
            mr_cap_q     <= mr_cap_d;
            mw_cap_q     <= mw_cap_d;
            wb_cap_q     <= wb_cap_d;
            alu_result_q <= alu_result_d;
            st_value_q   <= st_value_d;
            dest_q       <= dest_d;
            mem_r_en_q   <= mem_r_en_d;
            mem_w_en_q   <= mem_w_en_d;
            wb_en_q      <= wb_en_d;
            valid_q      <= valid_d;
        end
    end

    assign ALU_result = alu_result_q;
    assign ST_value   = st_value_q;
    assign dest       = dest_q;
    assign MEM_R_EN   = mem_r_en_q;
    assign MEM_W_EN   = mem_w_en_q;
    assign WB_EN      = wb_en_q;
    assign valid      = valid_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: ALU ops, bubbles, multi-cycle MUL, flush, reset.
// Inputs are driven 1ns after the rising edge; registered outputs are sampled there too,
// combinational stall is sampled on the falling edge.
module tb_exe_stage_mc;

    logic        clk;
    logic        rst;
    logic        validIn;
    logic        flush;
    logic [3:0]  EXE_CMD_IN;
    logic [31:0] val1In;
    logic [31:0] val2In;
    logic [31:0] ST_valueIn;
    logic [4:0]  destIn;
    logic        MEM_R_EN_IN;
    logic        MEM_W_EN_IN;
    logic        WB_EN_IN;
    logic [31:0] ALU_result;
    logic [31:0] ST_value;
    logic [4:0]  dest;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        WB_EN;
    logic        valid;
    logic        stall;

    int total;
    int bad;

    exe_stage_mc dut (
        .clk         (clk),
        .rst         (rst),
        .validIn     (validIn),
        .flush       (flush),
        .EXE_CMD_IN  (EXE_CMD_IN),
        .val1In      (val1In),
        .val2In      (val2In),
        .ST_valueIn  (ST_valueIn),
        .destIn      (destIn),
        .MEM_R_EN_IN (MEM_R_EN_IN),
        .MEM_W_EN_IN (MEM_W_EN_IN),
        .WB_EN_IN    (WB_EN_IN),
        .ALU_result  (ALU_result),
        .ST_value    (ST_value),
        .dest        (dest),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .WB_EN       (WB_EN),
        .valid       (valid),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] st, input logic [4:0] d,
                         input logic mr, input logic mw, input logic wb, input logic v);
        EXE_CMD_IN  = cmd;
        val1In      = a;
        val2In      = b;
        ST_valueIn  = st;
        destIn      = d;
        MEM_R_EN_IN = mr;
        MEM_W_EN_IN = mw;
        WB_EN_IN    = wb;
        validIn     = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[9];

    logic [31:0] rres[3];
    logic [4:0]  rdst[3];
    int          rcyc[3];

    initial begin
        int n_stall;
        int done_at;
        int bub_bad;
        int nres;
        int idx;
        int vcount;
        logic st_s;

        total = 0;
        bad   = 0;

        tbl[0] = '{4'b0010, 32'd5,         32'd7,         32'hFFFFFFFE};
        tbl[1] = '{4'b0100, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000};
        tbl[2] = '{4'b0101, 32'hF0F0F0F0,  32'h0F0F0000,  32'hFFFFF0F0};
        tbl[3] = '{4'b0110, 32'h0F0F0F0F,  32'hF0F00000,  32'h0000F0F0};
        tbl[4] = '{4'b0111, 32'hFFFF0000,  32'hFF00FF00,  32'h00FFFF00};
        tbl[5] = '{4'b1000, 32'h00000003,  32'h00000021,  32'h00000006};
        tbl[6] = '{4'b1001, 32'h80000000,  32'h0000001F,  32'h00000001};
        tbl[7] = '{4'b1010, 32'h80000000,  32'h00000024,  32'hF8000000};
        tbl[8] = '{4'b0011, 32'h12345678,  32'h00000001,  32'h00000000};

        // Reset with a MUL presented: outputs clear and stall stays low.
        rst   = 1'b1;
        flush = 1'b0;
        drive(4'b1100, 32'd3, 32'd4, 32'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
        #12;
        chk("rst_alu",   ALU_result, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_wb",    {31'd0, WB_EN}, 32'd0);
        chk("rst_dest",  {27'd0, dest}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        validIn = 1'b0;
        #1;
        rst = 1'b0;
        step();
        chk("post_rst_bubble", {31'd0, valid}, 32'd0);

        // ADD wraps modulo 2^32, single-cycle.
        drive(4'b0000, 32'hFFFFFFFF, 32'd1, 32'hCAFE0001, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("add_stall", {31'd0, stall}, 32'd0);
        step();
        chk("add_res",   ALU_result, 32'd0);
        chk("add_dest",  {27'd0, dest}, 32'd5);
        chk("add_ctl",   {28'd0, valid, WB_EN, MEM_R_EN, MEM_W_EN}, 32'b1100);
        chk("add_st",    ST_value, 32'hCAFE0001);

        // Table of single-cycle ops, with control bits varied per entry.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].cmd, tbl[i].a, tbl[i].b, 32'h100 + i, 5'(i + 10),
                  i[0], i[1], i[2], 1'b1);
            @(negedge clk);
            chk($sformatf("op%0d_stall", i), {31'd0, stall}, 32'd0);
            step();
            chk($sformatf("op%0d_res", i), ALU_result, tbl[i].exp);
            chk($sformatf("op%0d_dest", i), {27'd0, dest}, 32'(i + 10));
            chk($sformatf("op%0d_ctl", i), {28'd0, valid, WB_EN, MEM_R_EN, MEM_W_EN},
                {28'd0, 1'b1, i[2], i[0], i[1]});
        end

        // Bubble: valid and controls clear, data holds the last result (undefined op -> 0).
        drive(4'b0000, 32'd1, 32'd1, 32'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("bub_ctl",  {28'd0, valid, WB_EN, MEM_R_EN, MEM_W_EN}, 32'd0);
        chk("bub_dest", {27'd0, dest}, 32'd18);
        chk("bub_st",   ST_value, 32'h108);
        // A real SRA then a bubble: data must hold a nonzero value.
        drive(4'b1010, 32'h80000000, 32'h24, 32'h55, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        validIn = 1'b0;
        step();
        chk("bub_hold_res", ALU_result, 32'hF8000000);
        chk("bub_hold_vld", {31'd0, valid}, 32'd0);

        // MUL 7 * 0xFFFFFFFF; operands are scrambled during BUSY and must be ignored.
        drive(4'b1100, 32'd7, 32'hFFFFFFFF, 32'hABCD1234, 5'd12, 1'b0, 1'b1, 1'b1, 1'b1);
        n_stall = 0;
        done_at = 0;
        bub_bad = 0;
        for (int i = 1; i <= 40 && done_at == 0; i++) begin
            @(negedge clk);
            if (stall) n_stall++;
            step();
            if (valid) begin
                done_at = i;
            end else begin
                if (WB_EN || MEM_R_EN || MEM_W_EN) bub_bad++;
                val1In     = 32'h13579BDF + i;
                val2In     = 32'h2468ACE0 ^ i;
                ST_valueIn = 32'hDEAD0000 + i;
                destIn     = 5'(i);
            end
        end
        validIn = 1'b0;
        chk("mul_stall_cycles", n_stall, 32'd32);
        chk("mul_latency",      done_at, 32'd33);
        chk("mul_bubbles",      bub_bad, 32'd0);
        chk("mul_res",          ALU_result, 32'hFFFFFFF9);
        chk("mul_dest",         {27'd0, dest}, 32'd12);
        chk("mul_st",           ST_value, 32'hABCD1234);
        chk("mul_ctl",          {28'd0, valid, WB_EN, MEM_R_EN, MEM_W_EN}, 32'b1101);
        step();
        chk("mul_after_vld",    {31'd0, valid}, 32'd0);

        // Flush on the counter==31 cycle kills the result.
        drive(4'b1100, 32'd9, 32'd9, 32'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 31; i++) step();
        flush = 1'b1;
        #1;
        chk("flush_comb_stall", {31'd0, stall}, 32'd0);
        flush = 1'b0;
        #1;
        chk("busy_stall",       {31'd0, stall}, 32'd1);
        step();
        chk("cnt31_stall",      {31'd0, stall}, 32'd0);
        flush = 1'b1;
        step();
        flush   = 1'b0;
        validIn = 1'b0;
        chk("flush_ctl",   {28'd0, valid, WB_EN, MEM_R_EN, MEM_W_EN}, 32'd0);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_hold",  ALU_result, 32'hFFFFFFF9);
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (valid) vcount++;
        end
        chk("flush_no_res", vcount, 32'd0);
        drive(4'b0000, 32'd20, 32'd22, 32'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk("flush_then_add", ALU_result, 32'd42);
        chk("flush_then_vld", {31'd0, valid}, 32'd1);

        // Asynchronous reset between edges mid-MUL.
        drive(4'b1100, 32'd5, 32'd5, 32'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_alu",   ALU_result, 32'd0);
        chk("arst_dest",  {27'd0, dest}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        drive(4'b0000, 32'd100, 32'd23, 32'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        rst = 1'b0;
        step();
        chk("arst_add_res", ALU_result, 32'd123);
        chk("arst_add_vld", {31'd0, valid}, 32'd1);
        validIn = 1'b0;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valid) vcount++;
        end
        chk("arst_no_mul", vcount, 32'd0);

        // Back-to-back ADD, MUL, SUB with an upstream model that obeys stall.
        idx  = 0;
        nres = 0;
        for (int c = 1; c <= 60; c++) begin
            case (idx)
                0: drive(4'b0000, 32'd3,   32'd4, 32'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1);
                1: drive(4'b1100, 32'd6,   32'd7, 32'd0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
                2: drive(4'b0010, 32'd100, 32'd1, 32'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
                default: validIn = 1'b0;
            endcase
            @(negedge clk);
            st_s = stall;
            step();
            if (!st_s && idx < 3) idx++;
            if (valid) begin
                if (nres < 3) begin
                    rres[nres] = ALU_result;
                    rdst[nres] = dest;
                    rcyc[nres] = c;
                end
                nres++;
            end
        end
        chk("b2b_count", nres, 32'd3);
        chk("b2b_res0",  rres[0], 32'd7);
        chk("b2b_res1",  rres[1], 32'd42);
        chk("b2b_res2",  rres[2], 32'd99);
        chk("b2b_dst",   {17'd0, rdst[0], rdst[1], rdst[2]}, {17'd0, 5'd1, 5'd2, 5'd3});
        chk("b2b_cyc0",  rcyc[0], 32'd1);
        chk("b2b_cyc1",  rcyc[1], 32'd34);
        chk("b2b_cyc2",  rcyc[2], 32'd35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
